// File: rtl/mode_controller.sv
// Two-key front end: synchronizes and debounces active-low pushbuttons, turns
// debounced presses into single-cycle events, and steps a 2-bit mode register.
module mode_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key,
    output logic [1:0] mode_select,
    output logic       mode_change,
    output logic [1:0] key_pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       MODE_MAX = 2'(NUM_MODES - 1);

    logic [1:0]       sync1_q;
    logic [1:0]       ks_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       level_q;        // debounced raw level, 0 = held
    logic [1:0]       level_d;
    logic [1:0]       pressed;
    logic [1:0]       pressed_prev_q;
    logic [1:0]       press;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             change_q;
    logic             change_d;

    // Released keys read as 1, so the synchronizer resets high to avoid a
    // phantom press right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            ks_q    <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what builds a real two-stage chain.
            sync1_q <= key;
            ks_q    <= sync1_q;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and infers a latch.
        level_d = level_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (ks_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ks_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q        <= 2'b11;
            pressed_prev_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q        <= level_d;
            pressed_prev_q <= pressed;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pressed = ~level_q;
    assign press   = pressed & ~pressed_prev_q;

    always_comb begin
        mode_d = mode_q;
        case (press)
            2'b11:   mode_d = 2'd0;
            2'b01:   mode_d = (mode_q == MODE_MAX) ? 2'd0 : mode_q + 2'd1;
            2'b10:   mode_d = (mode_q == 2'd0) ? MODE_MAX : mode_q - 2'd1;
            default: mode_d = mode_q;
        endcase
        change_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 2'd0;
            change_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            change_q <= change_d;
        end
    end

    assign mode_select = mode_q;
    assign mode_change = change_q;
    assign key_pressed = pressed;

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: directed scenarios plus random key
// activity, compared every cycle against a window-based reference model.
module tb_mode_controller;

    localparam int D  = 4;
    localparam int NM = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key   = 2'b11;
    logic [1:0] mode_select;
    logic       mode_change;
    logic [1:0] key_pressed;

    mode_controller #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20),
        .NUM_MODES      (NM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .mode_select(mode_select),
        .mode_change(mode_change),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int chg_count = 0;

    // Reference model: key samples since reset release, debounced levels,
    // and the mode that the press rules produce.
    logic [1:0] samp [$];
    logic [1:0] m_db;
    logic [1:0] m_kp;
    logic [1:0] m_rose;
    logic [1:0] m_mode;
    logic       m_chg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample taken "back" edges ago counting the current edge as 1; before
    // release the synchronizer holds released (1) values.
    function automatic logic [1:0] seen(input int back);
        if (samp.size() >= back) return samp[samp.size() - back];
        return 2'b11;
    endfunction

    task automatic model_reset();
        samp.delete();
        m_db   = 2'b11;
        m_kp   = 2'b00;
        m_rose = 2'b00;
        m_mode = 2'd0;
        m_chg  = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] k);
        logic [1:0] nm;
        logic [1:0] kp_new;
        logic [1:0] s;
        bit         flip;
        nm = m_mode;
        if (m_rose == 2'b11)  nm = 2'd0;
        else if (m_rose[0])   nm = 2'((int'(m_mode) + 1) % NM);
        else if (m_rose[1])   nm = 2'((int'(m_mode) + NM - 1) % NM);
        m_chg  = (nm != m_mode);
        m_mode = nm;
        samp.push_back(k);
        if (samp.size() > D + 6) void'(samp.pop_front());
        // A level is accepted once the D most recent synchronized samples
        // (two edges behind the pins) all disagree with it.
        for (int i = 0; i < 2; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                s = seen(3 + j);
                if (s[i] == m_db[i]) flip = 1'b0;
            end
            if (flip) m_db[i] = ~m_db[i];
        end
        kp_new = ~m_db;
        m_rose = kp_new & ~m_kp;
        m_kp   = kp_new;
    endtask

    task automatic compare();
        check("key_pressed", 32'(key_pressed), 32'(m_kp));
        check("mode_select", 32'(mode_select), 32'(m_mode));
        check("mode_change", 32'(mode_change), 32'(m_chg));
        if (mode_change) chg_count++;
    endtask

    // Called and returns at a falling edge; drives key for one full cycle.
    task automatic tick(input logic [1:0] k);
        key = k;
        @(posedge clk);
        if (rst_n) model_edge(k);
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] k, input int n);
        repeat (n) tick(k);
    endtask

    task automatic do_reset(input int n, input logic [1:0] k);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        hold(k, n);
        rst_n = 1'b1;
    endtask

    task automatic press_key(input logic [1:0] k);
        hold(k, 8);
        hold(2'b11, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [1:0] exp_seq [4];
        model_reset();
        hold(2'b11, 20);
        rst_n = 1'b1;
        hold(2'b11, 20);
        check("idle_no_change", 32'(chg_count), 32'd0);

        // Clean key[0] press: level after edge 6, mode step at edge 7.
        for (int i = 1; i <= 10; i++) begin
            tick(2'b10);
            if (i == 5) check("kp_before_6", 32'(key_pressed), 32'd0);
            if (i == 6) check("kp_at_6", 32'(key_pressed), 32'd1);
            if (i == 7) check("mode_at_7", 32'(mode_select), 32'd1);
            if (i == 7) check("chg_at_7", 32'(mode_change), 32'd1);
            if (i == 8) check("chg_at_8", 32'(mode_change), 32'd0);
        end
        hold(2'b11, 12);
        check("release_mode", 32'(mode_select), 32'd1);

        // Short glitches must be filtered.
        do_reset(2, 2'b11);
        c0 = chg_count;
        repeat (5) begin
            hold(2'b10, 3);
            hold(2'b11, 2);
        end
        hold(2'b11, 8);
        check("glitch_mode", 32'(mode_select), 32'd0);
        check("glitch_chg", 32'(chg_count - c0), 32'd0);

        // Up-count wrap then down-count wrap.
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            press_key(2'b10);
            check("up_seq", 32'(mode_select), 32'(exp_seq[i]));
        end
        press_key(2'b01);
        check("down_wrap", 32'(mode_select), 32'd3);

        // Reset chord from mode 2, then from mode 0.
        do_reset(2, 2'b11);
        press_key(2'b10);
        press_key(2'b10);
        check("chord_setup", 32'(mode_select), 32'd2);
        c0 = chg_count;
        for (int i = 1; i <= 8; i++) begin
            tick(2'b00);
            if (i == 7) check("chord_mode_7", 32'(mode_select), 32'd0);
        end
        hold(2'b11, 8);
        check("chord_one_pulse", 32'(chg_count - c0), 32'd1);
        c0 = chg_count;
        press_key(2'b00);
        check("chord_at_zero", 32'(chg_count - c0), 32'd0);

        // Reset in the middle of a debounce, key still held at release.
        press_key(2'b10);
        hold(2'b10, 2);
        do_reset(2, 2'b10);
        c0 = chg_count;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b10);
            if (i == 6) check("rst_mode_6", 32'(mode_select), 32'd0);
            if (i == 7) check("rst_mode_7", 32'(mode_select), 32'd1);
        end
        hold(2'b11, 8);
        check("rst_one_press", 32'(chg_count - c0), 32'd1);

        // Random key activity with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom_range(1, 3), 2'($urandom_range(0, 3)));
            end
            hold(2'($urandom_range(0, 3)), $urandom_range(1, 9));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
